// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg: shared load-op encoding, entry flag struct and counter sizing.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

   // Bit positions inside ld_op = {ld_w, ld_b, ld_h, ld_bu, ld_hu}
   localparam int LD_W  = 4;
   localparam int LD_B  = 3;
   localparam int LD_H  = 2;
   localparam int LD_BU = 1;
   localparam int LD_HU = 0;

   // Per-entry control flags; the width-parameterised payload lives beside it
   typedef struct packed {
      logic       res_from_mem;
      logic       rf_we;
      logic [4:0] ld_op;
      logic       exc;
      logic       req;
      logic       filled;
   } mem_entry_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Discard counter must hold up to 2*DEPTH owed responses
   function automatic int cnt_w(input int depth);
      return clog2(2 * depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ---------------------------------------------------------------------------
// mem_load_align: byte/half extract and sign/zero extend of load data.
// Rev 1.0 | MEM_LOAD_EXTEND_EN enables sub-word loads (XLEN must be 32)
// ---------------------------------------------------------------------------
`default_nettype none

module mem_load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr_lo,
   input  logic [4:0]      ld_op,
   output logic [XLEN-1:0] result
);

`ifdef MEM_LOAD_EXTEND_EN
   logic [XLEN-1:0] shifted;

   assign shifted = word >> {addr_lo, 3'b000};

   always_comb begin
      result = word;
      if (ld_op[LD_W])
         result = word;
      else if (ld_op[LD_B])
         result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      else if (ld_op[LD_H])
         result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      else if (ld_op[LD_BU])
         result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      else if (ld_op[LD_HU])
         result = {{(XLEN-16){1'b0}}, shifted[15:0]};
   end
`else
   logic unused_sel;

   assign unused_sel = ^{addr_lo, ld_op};
   assign result     = word;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_load_stage.sv
// ---------------------------------------------------------------------------
// mem_load_stage: in-order EX->WB memory stage with DEPTH outstanding requests.
// Rev 1.0 | MEM_LOAD_EXTEND_EN handled inside mem_load_align
// ---------------------------------------------------------------------------
`default_nettype none

module mem_load_stage
   import mem_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_allowin,
   input  logic [31:0]      in_pc,
   input  logic             in_res_from_mem,
   input  logic             in_rf_we,
   input  logic [RF_AW-1:0] in_rf_waddr,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [4:0]       in_ld_op,
   input  logic             in_req,
   input  logic             in_exc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_allowin,
   output logic [31:0]      out_pc,
   output logic             out_rf_we,
   output logic [RF_AW-1:0] out_rf_waddr,
   output logic [XLEN-1:0]  out_rf_wdata,
   output logic             mem_exc,
   input  logic             data_ok,
   input  logic [XLEN-1:0]  rdata
);

   localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int OCC_W = clog2(DEPTH + 1);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [DEPTH-1:0] ent_valid;
   mem_entry_t       ent       [DEPTH];
   logic [31:0]      ent_pc    [DEPTH];
   logic [RF_AW-1:0] ent_waddr [DEPTH];
   logic [XLEN-1:0]  ent_alu   [DEPTH];
   logic [XLEN-1:0]  ent_data  [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [OCC_W-1:0] count;
   logic [CNT_W-1:0] discard_cnt;

   logic [DEPTH-1:0] waiting;
   logic [CNT_W-1:0] wait_cnt;
   logic [PTR_W-1:0] fill_idx;
   logic             fill_found;
   logic             discard_zero;
   logic             fill_en;
   logic             head_ready;
   logic             push;
   logic             pop;
   logic [XLEN-1:0]  head_word;
   logic [XLEN-1:0]  aligned;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   for (genvar i = 0; i < DEPTH; i++) begin : g_wait
      assign waiting[i] = ent_valid[i] & ent[i].req & ~ent[i].filled;
   end

   // Responses return in order, so the target is the first waiting entry from head
   always_comb begin
      fill_idx   = '0;
      fill_found = 1'b0;
      wait_cnt   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (!fill_found && waiting[(int'(head) + k) % DEPTH]) begin
            fill_found = 1'b1;
            fill_idx   = PTR_W'((int'(head) + k) % DEPTH);
         end
         wait_cnt = wait_cnt + CNT_W'(waiting[k]);
      end
   end

   assign discard_zero = (discard_cnt == '0);
   assign fill_en      = data_ok & discard_zero & fill_found;
   assign head_ready   = ent[head].filled | (fill_en & (fill_idx == head));

   assign in_allowin = (count < OCC_W'(DEPTH)) & ~flush;
   assign out_valid  = ent_valid[head] & head_ready & ~flush;
   assign push       = in_valid & in_allowin;
   assign pop        = out_valid & out_allowin;

   assign head_word = ent[head].filled ? ent_data[head] : rdata;

   mem_load_align #(
      .XLEN    (XLEN)
   ) u_align (
      .word    (head_word),
      .addr_lo (ent_alu[head][1:0]),
      .ld_op   (ent[head].ld_op),
      .result  (aligned)
   );

   assign out_pc       = ent_pc[head];
   assign out_rf_waddr = ent_waddr[head];
   assign out_rf_we    = ent[head].rf_we & out_valid;
   assign out_rf_wdata = ent[head].res_from_mem ? aligned : ent_alu[head];
   assign mem_exc      = ent_valid[head] & ent[head].exc;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ent_valid   <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         discard_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent[i]       <= '0;
            ent_pc[i]    <= '0;
            ent_waddr[i] <= '0;
            ent_alu[i]   <= '0;
            ent_data[i]  <= '0;
         end
      end else if (flush) begin
         ent_valid   <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         // Every still-waiting request will answer later; a fill this cycle pays one off
         discard_cnt <= discard_cnt + wait_cnt - CNT_W'(fill_en);
      end else begin
         if (data_ok && !discard_zero)
            discard_cnt <= discard_cnt - CNT_W'(1);
         if (fill_en) begin
            ent[fill_idx].filled <= 1'b1;
            ent_data[fill_idx]   <= rdata;
         end
         if (push) begin
            ent_valid[tail] <= 1'b1;
            ent[tail]       <= '{res_from_mem: in_res_from_mem, rf_we: in_rf_we,
                                 ld_op: in_ld_op, exc: in_exc, req: in_req,
                                 filled: ~in_req};
            ent_pc[tail]    <= in_pc;
            ent_waddr[tail] <= in_rf_waddr;
            ent_alu[tail]   <= in_alu_result;
            tail            <= ptr_inc(tail);
         end
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= ptr_inc(head);
         end
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (resetn && data_ok && discard_zero)
         assert (fill_found) else $error("mem_load_stage: data_ok with no outstanding request");
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_load_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_load_stage: directed self-checking bench for mem_load_stage.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_load_stage;

   localparam logic [4:0] LDW  = 5'b10000;
   localparam logic [4:0] LDB  = 5'b01000;
   localparam logic [4:0] LDH  = 5'b00100;
   localparam logic [4:0] LDBU = 5'b00010;
   localparam logic [4:0] LDHU = 5'b00001;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_allowin;
   logic [31:0] in_pc;
   logic        in_res_from_mem;
   logic        in_rf_we;
   logic [4:0]  in_rf_waddr;
   logic [31:0] in_alu_result;
   logic [4:0]  in_ld_op;
   logic        in_req;
   logic        in_exc;
   logic        flush;
   logic        out_valid;
   logic        out_allowin;
   logic [31:0] out_pc;
   logic        out_rf_we;
   logic [4:0]  out_rf_waddr;
   logic [31:0] out_rf_wdata;
   logic        mem_exc;
   logic        data_ok;
   logic [31:0] rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_load_stage #(.XLEN(32), .DEPTH(2), .RF_AW(5)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .in_valid        (in_valid),
      .in_allowin      (in_allowin),
      .in_pc           (in_pc),
      .in_res_from_mem (in_res_from_mem),
      .in_rf_we        (in_rf_we),
      .in_rf_waddr     (in_rf_waddr),
      .in_alu_result   (in_alu_result),
      .in_ld_op        (in_ld_op),
      .in_req          (in_req),
      .in_exc          (in_exc),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_allowin     (out_allowin),
      .out_pc          (out_pc),
      .out_rf_we       (out_rf_we),
      .out_rf_waddr    (out_rf_waddr),
      .out_rf_wdata    (out_rf_wdata),
      .mem_exc         (mem_exc),
      .data_ok         (data_ok),
      .rdata           (rdata)
   );

   task step();
      @(posedge clk);
      #1;
   endtask

   task push_in(input logic [31:0] pc, input logic rfm, input logic we,
                input logic [4:0] wa, input logic [31:0] alu, input logic [4:0] op,
                input logic req, input logic exc);
      in_valid        = 1'b1;
      in_pc           = pc;
      in_res_from_mem = rfm;
      in_rf_we        = we;
      in_rf_waddr     = wa;
      in_alu_result   = alu;
      in_ld_op        = op;
      in_req          = req;
      in_exc          = exc;
   endtask

   task no_in();
      in_valid = 1'b0;
      in_req   = 1'b0;
      in_exc   = 1'b0;
   endtask

   task test_reset();
      resetn = 1'b0; flush = 1'b0; data_ok = 1'b0; rdata = '0; out_allowin = 1'b1;
      in_pc = '0; in_res_from_mem = 1'b0; in_rf_we = 1'b0; in_rf_waddr = '0;
      in_alu_result = '0; in_ld_op = '0;
      no_in();
      step(); step(); #2;
      n_cmp++; if (in_allowin !== 1'b1) begin n_err++; $display("FAIL rst_allowin got %0h want 1", in_allowin); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
      n_cmp++; if (out_rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we got %0h want 0", out_rf_we); end
      n_cmp++; if (mem_exc !== 1'b0) begin n_err++; $display("FAIL rst_mem_exc got %0h want 0", mem_exc); end
      n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %0h want 0", out_pc); end
      n_cmp++; if (out_rf_waddr !== 5'h0) begin n_err++; $display("FAIL rst_waddr got %0h want 0", out_rf_waddr); end
      n_cmp++; if (out_rf_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata got %0h want 0", out_rf_wdata); end
      resetn = 1'b1;
   endtask

   task test_bypass();
      step(); push_in(32'h100, 1, 1, 5'd1, 32'h1000, LDW, 1, 0); #2;
      n_cmp++; if (in_allowin !== 1'b1) begin n_err++; $display("FAIL bp_allowin0 got %0h want 1", in_allowin); end
      step(); push_in(32'h104, 1, 1, 5'd2, 32'h1004, LDW, 1, 0); #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_wait got %0h want 0", out_valid); end
      step(); no_in(); data_ok = 1'b1; rdata = 32'h11111111; #2;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_v1 got %0h want 1", out_valid); end
      n_cmp++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL bp_pc1 got %0h want 100", out_pc); end
      n_cmp++; if (out_rf_wdata !== 32'h11111111) begin n_err++; $display("FAIL bp_d1 got %0h want 11111111", out_rf_wdata); end
      n_cmp++; if (out_rf_we !== 1'b1 || out_rf_waddr !== 5'd1) begin n_err++; $display("FAIL bp_wa1 got %0h/%0h want 1/1", out_rf_we, out_rf_waddr); end
      n_cmp++; if (in_allowin !== 1'b0) begin n_err++; $display("FAIL bp_full got %0h want 0", in_allowin); end
      step(); rdata = 32'h22222222; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin n_err++; $display("FAIL bp_v2 got %0h/%0h want 1/104", out_valid, out_pc); end
      n_cmp++; if (out_rf_wdata !== 32'h22222222) begin n_err++; $display("FAIL bp_d2 got %0h want 22222222", out_rf_wdata); end
      step(); data_ok = 1'b0; #2;
      n_cmp++; if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin n_err++; $display("FAIL bp_empty got %0h/%0h want 0/1", out_valid, in_allowin); end
   endtask

   task test_extend();
      logic [31:0] exp_b, exp_hu, exp_h, exp_bu;
`ifdef MEM_LOAD_EXTEND_EN
      exp_b = 32'hFFFFFF80; exp_hu = 32'h000080FF; exp_h = 32'hFFFF8001; exp_bu = 32'h000000FF;
`else
      exp_b = 32'h80FF0000; exp_hu = 32'h80FF0000; exp_h = 32'h00008001; exp_bu = 32'h80FF0000;
`endif
      step(); push_in(32'h700, 1, 1, 5'd3, 32'h1003, LDB, 1, 0);
      step(); no_in(); data_ok = 1'b1; rdata = 32'h80FF0000; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_rf_wdata !== exp_b) begin n_err++; $display("FAIL ext_ldb got %0h want %0h", out_rf_wdata, exp_b); end
      step(); data_ok = 1'b0; push_in(32'h704, 1, 1, 5'd3, 32'h1002, LDHU, 1, 0);
      step(); no_in(); data_ok = 1'b1; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_rf_wdata !== exp_hu) begin n_err++; $display("FAIL ext_ldhu got %0h want %0h", out_rf_wdata, exp_hu); end
      step(); data_ok = 1'b0; push_in(32'h708, 1, 1, 5'd3, 32'h1000, LDH, 1, 0);
      step(); no_in(); data_ok = 1'b1; rdata = 32'h00008001; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_rf_wdata !== exp_h) begin n_err++; $display("FAIL ext_ldh got %0h want %0h", out_rf_wdata, exp_h); end
      step(); data_ok = 1'b0; push_in(32'h70C, 1, 1, 5'd3, 32'h1002, LDBU, 1, 0);
      step(); no_in(); data_ok = 1'b1; rdata = 32'h80FF0000; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_rf_wdata !== exp_bu) begin n_err++; $display("FAIL ext_ldbu got %0h want %0h", out_rf_wdata, exp_bu); end
      step(); data_ok = 1'b0;
   endtask

   task test_flush_discard();
      step(); push_in(32'h200, 1, 1, 5'd4, 32'h2000, LDW, 1, 0);
      step(); push_in(32'h204, 1, 1, 5'd5, 32'h2004, LDW, 1, 0);
      step(); no_in(); flush = 1'b1; #2;
      n_cmp++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin n_err++; $display("FAIL fd_flush got %0h/%0h want 0/0", out_valid, in_allowin); end
      step(); flush = 1'b0; push_in(32'h208, 1, 1, 5'd8, 32'h2008, LDW, 1, 0); #2;
      n_cmp++; if (in_allowin !== 1'b1) begin n_err++; $display("FAIL fd_allowin got %0h want 1", in_allowin); end
      step(); no_in(); data_ok = 1'b1; rdata = 32'hA; #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fd_discA got %0h want 0", out_valid); end
      step(); rdata = 32'hB; #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fd_discB got %0h want 0", out_valid); end
      step(); rdata = 32'hC; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h208) begin n_err++; $display("FAIL fd_v got %0h/%0h want 1/208", out_valid, out_pc); end
      n_cmp++; if (out_rf_wdata !== 32'hC || out_rf_waddr !== 5'd8) begin n_err++; $display("FAIL fd_d got %0h/%0h want c/8", out_rf_wdata, out_rf_waddr); end
      step(); data_ok = 1'b0; #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fd_empty got %0h want 0", out_valid); end
   endtask

   task test_flush_same_cycle();
      step(); push_in(32'h300, 1, 1, 5'd6, 32'h3000, LDW, 1, 0);
      step(); no_in(); flush = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD; #2;
      n_cmp++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin n_err++; $display("FAIL fs_prio got %0h/%0h want 0/0", out_valid, in_allowin); end
      step(); flush = 1'b0; data_ok = 1'b0; push_in(32'h304, 1, 1, 5'd4, 32'h3004, LDW, 1, 0);
      step(); no_in(); data_ok = 1'b1; rdata = 32'h1234; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h304) begin n_err++; $display("FAIL fs_v got %0h/%0h want 1/304", out_valid, out_pc); end
      n_cmp++; if (out_rf_wdata !== 32'h1234) begin n_err++; $display("FAIL fs_d got %0h want 1234", out_rf_wdata); end
      step(); data_ok = 1'b0;
   endtask

   task test_full_stall();
      out_allowin = 1'b0;
      step(); push_in(32'h400, 1, 1, 5'd5, 32'h4000, LDW, 1, 0);
      step(); push_in(32'h404, 1, 1, 5'd6, 32'h4004, LDW, 1, 0);
      step(); no_in(); data_ok = 1'b1; rdata = 32'h55; #2;
      n_cmp++; if (in_allowin !== 1'b0) begin n_err++; $display("FAIL st_full got %0h want 0", in_allowin); end
      n_cmp++; if (out_valid !== 1'b1 || out_rf_wdata !== 32'h55) begin n_err++; $display("FAIL st_v1 got %0h/%0h want 1/55", out_valid, out_rf_wdata); end
      step(); rdata = 32'h66; #2;
      n_cmp++; if (out_pc !== 32'h400 || out_rf_wdata !== 32'h55) begin n_err++; $display("FAIL st_hold got %0h/%0h want 400/55", out_pc, out_rf_wdata); end
      step(); data_ok = 1'b0; rdata = 32'hFFFF; out_allowin = 1'b1; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_rf_wdata !== 32'h55) begin n_err++; $display("FAIL st_pop1 got %0h/%0h want 1/55", out_valid, out_rf_wdata); end
      step(); #2;
      n_cmp++; if (out_pc !== 32'h404 || out_rf_wdata !== 32'h66) begin n_err++; $display("FAIL st_pop2 got %0h/%0h want 404/66", out_pc, out_rf_wdata); end
      n_cmp++; if (in_allowin !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL st_space got %0h/%0h want 1/1", in_allowin, out_valid); end
      step(); #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL st_empty got %0h want 0", out_valid); end
   endtask

   task test_exc();
      step(); push_in(32'h500, 0, 1, 5'd9, 32'hCAFE0001, 5'b0, 0, 1); #2;
      n_cmp++; if (mem_exc !== 1'b0) begin n_err++; $display("FAIL ex_early got %0h want 0", mem_exc); end
      step(); no_in(); #2;
      n_cmp++; if (mem_exc !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL ex_flag got %0h/%0h want 1/1", mem_exc, out_valid); end
      n_cmp++; if (out_rf_wdata !== 32'hCAFE0001 || out_rf_we !== 1'b1) begin n_err++; $display("FAIL ex_data got %0h/%0h want cafe0001/1", out_rf_wdata, out_rf_we); end
      step(); #2;
      n_cmp++; if (mem_exc !== 1'b0) begin n_err++; $display("FAIL ex_clear got %0h want 0", mem_exc); end
   endtask

   task test_back_to_back();
      step(); push_in(32'h600, 0, 1, 5'd7, 32'h77, 5'b0, 0, 0);
      step(); push_in(32'h604, 0, 0, 5'd0, 32'h3000, 5'b0, 1, 0); #2;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h600 || out_rf_wdata !== 32'h77) begin n_err++; $display("FAIL bb_alu got %0h/%0h/%0h want 1/600/77", out_valid, out_pc, out_rf_wdata); end
      step(); push_in(32'h608, 0, 1, 5'd9, 32'h99, 5'b0, 0, 0); #2;
      n_cmp++; if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin n_err++; $display("FAIL bb_store_wait got %0h/%0h want 0/1", out_valid, in_allowin); end
      step(); no_in(); data_ok = 1'b1; rdata = 32'hBEEF; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h604 || out_rf_we !== 1'b0) begin n_err++; $display("FAIL bb_store got %0h/%0h/%0h want 1/604/0", out_valid, out_pc, out_rf_we); end
      step(); data_ok = 1'b0; #2;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h608 || out_rf_wdata !== 32'h99 || out_rf_waddr !== 5'd9) begin n_err++; $display("FAIL bb_wrap got %0h/%0h/%0h want 1/608/99", out_valid, out_pc, out_rf_wdata); end
      step(); #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bb_empty got %0h want 0", out_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_bypass();
      test_extend();
      test_flush_discard();
      test_flush_same_cycle();
      test_full_stall();
      test_exc();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_load_stage.md
# mem_load_stage

Parametrised in-order memory stage that sits between EX and WB. It holds up to `DEPTH` in-flight instructions, so several data-SRAM loads can be outstanding at once. Read data arriving on `data_ok` is matched in order to the oldest waiting entry, then byte/half-aligned, sign- or zero-extended and presented to WB. A WB flush empties the stage and discards the responses still owed for flushed requests.

## Interface
Parameters:
- `XLEN`, 32: datapath width; must be 32 when byte/half extension is compiled in.
- `DEPTH`, 2: entry count (≥1); also the maximum number of live outstanding requests.
- `RF_AW`, 5: register-file address width.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  EX presents an instruction
- `in_allowin`  out  1  stage accepts this cycle
- `in_pc`  in  32  instruction PC
- `in_res_from_mem`  in  1  write-back value comes from memory
- `in_rf_we`  in  1  register write enable
- `in_rf_waddr`  in  RF_AW  destination register
- `in_alu_result`  in  XLEN  address or ALU result
- `in_ld_op`  in  5  {ld_w, ld_b, ld_h, ld_bu, ld_hu}
- `in_req`  in  1  EX issued a data request for this instruction
- `in_exc`  in  1  instruction already carries an exception
- `flush`  in  1  WB exception/ertn flush
- `out_valid`  out  1  head entry is ready for WB
- `out_allowin`  in  1  WB accepts
- `out_pc`  out  32  head PC
- `out_rf_we`  out  1  `head.rf_we & out_valid`
- `out_rf_waddr`  out  RF_AW  head destination register
- `out_rf_wdata`  out  XLEN  aligned load data or ALU result
- `mem_exc`  out  1  head entry is valid and has `exc` set
- `data_ok`  in  1  SRAM read/write response
- `rdata`  in  XLEN  SRAM read data

## Operation
Entries form a circular FIFO. Each entry holds: `pc, res_from_mem, rf_we, waddr, alu_result, ld_op, exc, req, filled, data`.

- **Push:** when `in_valid & in_allowin`. A pushed entry has `filled = ~in_req`.
- **Fill:** a `data_ok` with `discard_cnt == 0` fills the oldest valid entry that has `req & ~filled`. A `data_ok` with `discard_cnt > 0` decrements `discard_cnt` and fills nothing.
- **Head readiness:** the head is ready when `filled`, or when it is waiting and the current `data_ok` targets it (same-cycle bypass of `rdata`).
- **Pop:** when `out_valid & out_allowin`.
- **Flush:** all entries are invalidated. `discard_cnt` becomes `discard_cnt + W − (data_ok & discard_cnt==0)`, where `W` is the number of valid entries with `req & ~filled`.
- **Write-data select:** `out_rf_wdata = res_from_mem ? align(data or rdata, alu_result[1:0], ld_op) : alu_result`.
- **Store responses:** `data_ok` also answers stores; store entries set `req` and write nothing to the register file.
- **Protocol error:** a `data_ok` with no waiting entry and `discard_cnt == 0` is an error. The implementation asserts in simulation and ignores the event.

## Timing
- **Reset:** all entries invalid, pointers 0, `discard_cnt` 0.
  - `in_allowin` = 1.
  - `out_valid`, `out_rf_we`, `mem_exc` = 0.
  - `out_pc`, `out_rf_waddr`, `out_rf_wdata` = 0.
- **Handshake signals:**
  - `in_allowin = (count < DEPTH) & ~flush`. There is no push-through when full.
  - `out_valid = head_valid & head_ready & ~flush`.
- **Latency:**
  - Non-load, or load whose data arrives in the cycle after push: `out_valid` rises the cycle after push.
  - Bypass path: data returned on cycle N reaches WB on cycle N, combinationally.
- **Simultaneous events:**
  - Push and pop in the same cycle keep `count` unchanged.
  - Pointers wrap modulo `DEPTH`.
  - Flush takes priority over push, pop and fill in the same cycle.
- **`discard_cnt`:**
  - Width is clog2(2·DEPTH+1). EX must not issue a request in a flush cycle.
  - The stage may accept new instructions while `discard_cnt > 0`. Their responses arrive after the discarded ones.
- **Reset mid-operation:** all state is cleared. Stale responses after reset are the SRAM interface's responsibility.

## Configuration
`MEM_LOAD_EXTEND_EN`:
- **Defined:** full `ld_b`/`ld_h`/`ld_bu`/`ld_hu` support.
  - Data is shifted right by `alu_result[1:0]·8`.
  - b/h sign-extend from bit 7/15; bu/hu zero-extend.
- **Undefined:** `align()` returns the word unchanged, `ld_op` is ignored, and `XLEN` may be any width.

## Structure
- **Shared package `mem_pkg`:**
  - `ld_op` bit-index constants.
  - Packed struct `mem_entry_t`.
  - Function `clog2`-based `CNT_W` helper.
- **Sub-module `mem_load_align`:** combinational extract/extend. It is the only place `MEM_LOAD_EXTEND_EN` is tested.
- **Top level:** FIFO, fill pointer, discard counter, handshake.

## Test plan
1. DEPTH=2, two `ld_w` back-to-back with `data_ok` on cycles 3 and 4 and `rdata` 0x11111111 / 0x22222222 → WB receives both in order, each on its `data_ok` cycle (bypass).
2. `ld_b` at `alu_result` 0x1003, `rdata` 0x80FF0000 → `out_rf_wdata` 0xFFFFFF80. `ld_hu` at 0x1002, same data → 0x000080FF.
3. Two loads outstanding, `flush` with no `data_ok` → `discard_cnt` = 2. Then a new load plus three `data_ok` responses (0xA, 0xB, 0xC) → only 0xC is written back.
4. `flush` in the same cycle as `data_ok` with one waiting entry → `discard_cnt` stays 0, and the next `data_ok` fills the next pushed load.
5. `out_allowin` held at 0 with stage full → `in_allowin` = 0. `data_ok` still fills the entries, and two pops follow once `out_allowin` = 1.
6. ALU op with `in_exc` = 1 → `mem_exc` = 1 on the following cycle, `out_rf_wdata` = `alu_result`.
